sram_stage_sequencer: RTL and testbench
=======================================

Name: sram_stage_sequencer

Overview:
- Top-level scheduler for the shared external SRAM port.
- Sequences the full decode flow: UART image receive, then M3 (lossless decode), M2 (IDCT), M1 (upsample/colour-space conversion), then returns SRAM ownership to the VGA reader.
- Muxes address, write data and write enable from the current owner onto the SRAM controller request port.
- Adds an inter-stage guard cycle, per-stage skip control and a watchdog.

Parameters:
- UART_TIMEOUT, 50_000_000: idle cycles after the last UART SRAM write before the receive phase is declared finished.
- WATCHDOG_CYCLES, 0: maximum cycles any milestone stage may run; 0 disables the watchdog.
- ADDR_W, 18: SRAM address width.
- DATA_W, 16: SRAM data width.

Ports:
- CLOCK_50_I  in  1  system clock, 50 MHz
- resetn  in  1  asynchronous, active-low reset
- uart_rx_i  in  1  raw UART line; low = start bit
- stage_enable  in  3  {M1,M2,M3} run enables; bit=0 skips that stage
- uart_rx_initialize  out  1  UART interface init pulse
- uart_rx_enable  out  1  UART interface enable pulse
- uart_address / uart_write_data / uart_we_n  in  ADDR_W/DATA_W/1  UART SRAM request
- mN_start  out  1  (N=1,2,3) stage run level
- mN_end  in  1  stage completion pulse
- mN_address / mN_write_data / mN_we_n  in  ADDR_W/DATA_W/1  stage SRAM request
- vga_address  in  ADDR_W  VGA read address
- vga_enable  out  1  VGA reader enable
- SRAM_address / SRAM_write_data / SRAM_we_n  out  ADDR_W/DATA_W/1  to SRAM controller
- owner  out  3  current owner_t, for LEDs and debug
- busy  out  1  high in every state except S_IDLE
- error  out  1  sticky watchdog-abort flag

Behaviour:
- Reset (async, all outputs): state S_IDLE, owner OWN_VGA, vga_enable=1, all mN_start=0, uart_rx_initialize=0, uart_rx_enable=0, error=0, timers=0, SRAM_we_n=1.
- SRAM mux:
  - Combinational from the registered owner.
  - OWN_VGA: vga_address, we_n=1.
  - OWN_UART / OWN_Mx: that requester's address, data and we_n.
  - OWN_NONE: address 0, we_n=1.
  - Write data is UART data unless an Mx stage owns the port.
- States: S_IDLE, S_UART_RX, S_GAP, S_M3, S_M2, S_M1.
- S_IDLE:
  - Sample uart_rx_i each cycle. On uart_rx_i=0 at edge k, at k+1: state S_UART_RX, owner OWN_UART, vga_enable=0, error=0, uart_rx_initialize=1, UART timer=0.
  - At k+2: initialize=0, uart_rx_enable=1. At k+3: uart_rx_enable=0. Both are single-cycle pulses.
- S_UART_RX:
  - Timer increments each cycle and clears on any cycle with uart_we_n=0.
  - When timer == UART_TIMEOUT-1: latch stage_enable into en_q, owner OWN_NONE, go to S_GAP.
  - uart_rx_i is ignored outside S_IDLE.
- S_GAP (exactly 1 cycle, we_n forced 1):
  - Go to the next enabled stage in order M3, M2, M1 after the last stage completed.
  - If none remain: go to S_IDLE, owner OWN_VGA, vga_enable=1.
- S_Mx:
  - On entry: owner OWN_Mx and mx_start=1, held high for the stage's duration.
  - On mx_end=1 at edge j: mx_start=0 and owner OWN_NONE at j+1, state S_GAP.
  - mN_end from any non-active stage is ignored.
  - Simultaneous mx_end and watchdog expiry: treated as normal completion.
- Watchdog (WATCHDOG_CYCLES>0):
  - Counter clears on stage entry and increments each cycle in S_Mx.
  - On reaching WATCHDOG_CYCLES without mx_end: mx_start=0, error=1, go directly to S_IDLE with owner OWN_VGA and vga_enable=1.
- stage_enable changes after latching have no effect until the next receive.
- busy=1 in every state except S_IDLE.
- Reset asserted mid-stage: immediate return to reset values; stages see start fall asynchronously.

Decomposition:
- Package sram_seq_pkg:
  - owner_t enum: OWN_VGA, OWN_UART, OWN_M3, OWN_M2, OWN_M1, OWN_NONE.
  - seq_state_t enum: the six states above.
  - Index constants for stage_enable bits (M3=0, M2=1, M1=2).
- Sub-module sram_port_mux: purely combinational owner-to-port select, kept separate so the FSM file holds only sequential logic.
- Watchdog and UART timer stay inline.

Test Plan:
- UART_TIMEOUT=100, stage_enable=3'b111: drive uart_rx_i low, 5 uart_we_n pulses 10 cycles apart. Required: after the last write, exactly 100 cycles then S_GAP; m3_start rises 1 cycle later; init/enable pulses at k+1/k+2.
- Stage chaining: pulse m3_end after 20 cycles and m2_end after 30. Required: one OWN_NONE cycle with SRAM_we_n=1 between each stage; m1_start follows; after m1_end, vga_enable=1 and owner=OWN_VGA two cycles later.
- stage_enable=3'b010 (M2 only): only m2_start ever asserts; S_GAP goes straight to S_M2, then back to S_IDLE.
- WATCHDOG_CYCLES=50, m3_end never pulsed: m3_start drops at cycle 50 of the stage, error=1, state S_IDLE. A new UART start bit clears error.
- Spurious m1_end and uart_rx_i=0 during S_M3: no state change, owner stays OWN_M3, SRAM_* mirrors m3_* exactly.
- Assert resetn=0 mid-S_M2 for 3 cycles: all outputs return to reset values asynchronously; the flow restarts only on a new start bit.

Source files
------------

// File: rtl/sram_seq_pkg.sv
// rtl/sram_seq_pkg.sv - shared types and constants for the SRAM stage sequencer
package sram_seq_pkg;

  // Current SRAM port owner, also exported on the debug/LED port
  typedef enum logic [2:0] {
    OWN_VGA  = 3'd0,
    OWN_UART = 3'd1,
    OWN_M3   = 3'd2,
    OWN_M2   = 3'd3,
    OWN_M1   = 3'd4,
    OWN_NONE = 3'd5
  } owner_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UART_RX = 3'd1,
    S_GAP     = 3'd2,
    S_M3      = 3'd3,
    S_M2      = 3'd4,
    S_M1      = 3'd5
  } seq_state_t;

  // Bit positions inside stage_enable
  localparam int IDX_M3 = 0;
  localparam int IDX_M2 = 1;
  localparam int IDX_M1 = 2;

endpackage

// File: rtl/sram_stage_sequencer_if.sv
// rtl/sram_stage_sequencer_if.sv - one SRAM request bundle (address, write data, write enable)
interface sram_stage_sequencer_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic              we_n;

  modport master (output address, output write_data, output we_n);
  modport slave  (input address, input write_data, input we_n);
endinterface

// File: rtl/sram_stage_sequencer_port_mux.sv
// rtl/sram_stage_sequencer_port_mux.sv - combinational owner-to-SRAM-port select
module sram_port_mux
  import sram_seq_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  owner_t            i_owner,
  input  logic [ADDR_W-1:0] i_vga_address,
  input  logic [ADDR_W-1:0] i_uart_address,
  input  logic [DATA_W-1:0] i_uart_write_data,
  input  logic              i_uart_we_n,
  input  logic [ADDR_W-1:0] i_m1_address,
  input  logic [DATA_W-1:0] i_m1_write_data,
  input  logic              i_m1_we_n,
  input  logic [ADDR_W-1:0] i_m2_address,
  input  logic [DATA_W-1:0] i_m2_write_data,
  input  logic              i_m2_we_n,
  input  logic [ADDR_W-1:0] i_m3_address,
  input  logic [DATA_W-1:0] i_m3_write_data,
  input  logic              i_m3_we_n,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_write_data,
  output logic              o_we_n
);

  // Route the owning requester; VGA and the idle owner can never write
  always_comb begin
    o_address    = '0;
    o_write_data = i_uart_write_data;
    o_we_n       = 1'b1;
    case (i_owner)
      OWN_VGA:  o_address = i_vga_address;
      OWN_UART: begin
        o_address = i_uart_address;
        o_we_n    = i_uart_we_n;
      end
      OWN_M3: begin
        o_address    = i_m3_address;
        o_write_data = i_m3_write_data;
        o_we_n       = i_m3_we_n;
      end
      OWN_M2: begin
        o_address    = i_m2_address;
        o_write_data = i_m2_write_data;
        o_we_n       = i_m2_we_n;
      end
      OWN_M1: begin
        o_address    = i_m1_address;
        o_write_data = i_m1_write_data;
        o_we_n       = i_m1_we_n;
      end
      default: o_address = '0;
    endcase
  end

endmodule

// File: rtl/sram_stage_sequencer.sv
// rtl/sram_stage_sequencer.sv - decode-flow scheduler owning the shared SRAM port
module sram_stage_sequencer
  import sram_seq_pkg::*;
#(
  parameter int UART_TIMEOUT    = 50_000_000,
  parameter int WATCHDOG_CYCLES = 0,
  parameter int ADDR_W          = 18,
  parameter int DATA_W          = 16
) (
  input  logic                   CLOCK_50_I,
  input  logic                   resetn,
  input  logic                   uart_rx_i,
  input  logic [2:0]             stage_enable,
  output logic                   uart_rx_initialize,
  output logic                   uart_rx_enable,
  sram_stage_sequencer_if.slave  uart_req,
  output logic                   m1_start,
  output logic                   m2_start,
  output logic                   m3_start,
  input  logic                   m1_end,
  input  logic                   m2_end,
  input  logic                   m3_end,
  sram_stage_sequencer_if.slave  m1_req,
  sram_stage_sequencer_if.slave  m2_req,
  sram_stage_sequencer_if.slave  m3_req,
  input  logic [ADDR_W-1:0]      vga_address,
  output logic                   vga_enable,
  sram_stage_sequencer_if.master sram_req,
  output owner_t                 owner,
  output logic                   busy,
  output logic                   error
);

  localparam logic [31:0] UART_LAST = 32'(UART_TIMEOUT - 1);
  localparam logic [31:0] WD_LAST   = 32'(WATCHDOG_CYCLES - 1);
  localparam bit          WD_ON     = (WATCHDOG_CYCLES > 0);

  seq_state_t  r_state;
  owner_t      r_owner;
  logic        r_m1_start, r_m2_start, r_m3_start;
  logic        r_vga_en, r_init, r_uen, r_err;
  logic [31:0] r_uart_tmr;
  logic [31:0] r_wd;
  logic [2:0]  r_en_q;
  logic        w_stage_end;

  // Only the running stage's completion pulse is honoured
  assign w_stage_end = ((r_state == S_M3) && m3_end) ||
                       ((r_state == S_M2) && m2_end) ||
                       ((r_state == S_M1) && m1_end);

  assign owner              = r_owner;
  assign m1_start           = r_m1_start;
  assign m2_start           = r_m2_start;
  assign m3_start           = r_m3_start;
  assign vga_enable         = r_vga_en;
  assign uart_rx_initialize = r_init;
  assign uart_rx_enable     = r_uen;
  assign error              = r_err;
  assign busy               = (r_state != S_IDLE);

  sram_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .i_owner           (r_owner),
    .i_vga_address     (vga_address),
    .i_uart_address    (uart_req.address),
    .i_uart_write_data (uart_req.write_data),
    .i_uart_we_n       (uart_req.we_n),
    .i_m1_address      (m1_req.address),
    .i_m1_write_data   (m1_req.write_data),
    .i_m1_we_n         (m1_req.we_n),
    .i_m2_address      (m2_req.address),
    .i_m2_write_data   (m2_req.write_data),
    .i_m2_we_n         (m2_req.we_n),
    .i_m3_address      (m3_req.address),
    .i_m3_write_data   (m3_req.write_data),
    .i_m3_we_n         (m3_req.we_n),
    .o_address         (sram_req.address),
    .o_write_data      (sram_req.write_data),
    .o_we_n            (sram_req.we_n)
  );

  // Sequencer FSM: receive, guard cycle, stages M3/M2/M1, watchdog abort
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_owner    <= OWN_VGA;
      r_m1_start <= 1'b0;
      r_m2_start <= 1'b0;
      r_m3_start <= 1'b0;
      r_vga_en   <= 1'b1;
      r_init     <= 1'b0;
      r_uen      <= 1'b0;
      r_err      <= 1'b0;
      r_uart_tmr <= '0;
      r_wd       <= '0;
      r_en_q     <= '0;
    end else begin
      // init and enable are back-to-back single-cycle pulses
      r_init <= 1'b0;
      r_uen  <= r_init;
      case (r_state)
        S_IDLE: begin
          if (!uart_rx_i) begin
            r_state    <= S_UART_RX;
            r_owner    <= OWN_UART;
            r_vga_en   <= 1'b0;
            r_err      <= 1'b0;
            r_init     <= 1'b1;
            r_uart_tmr <= '0;
          end
        end
        S_UART_RX: begin
          if (!uart_req.we_n) begin
            r_uart_tmr <= '0;
          end else if (r_uart_tmr == UART_LAST) begin
            r_en_q  <= stage_enable;
            r_owner <= OWN_NONE;
            r_state <= S_GAP;
          end else begin
            r_uart_tmr <= r_uart_tmr + 32'd1;
          end
        end
        S_GAP: begin
          r_wd <= '0;
          if (r_en_q[IDX_M3]) begin
            r_en_q[IDX_M3] <= 1'b0;
            r_state        <= S_M3;
            r_owner        <= OWN_M3;
            r_m3_start     <= 1'b1;
          end else if (r_en_q[IDX_M2]) begin
            r_en_q[IDX_M2] <= 1'b0;
            r_state        <= S_M2;
            r_owner        <= OWN_M2;
            r_m2_start     <= 1'b1;
          end else if (r_en_q[IDX_M1]) begin
            r_en_q[IDX_M1] <= 1'b0;
            r_state        <= S_M1;
            r_owner        <= OWN_M1;
            r_m1_start     <= 1'b1;
          end else begin
            r_state  <= S_IDLE;
            r_owner  <= OWN_VGA;
            r_vga_en <= 1'b1;
          end
        end
        S_M3, S_M2, S_M1: begin
          // Completion wins over a watchdog expiry in the same cycle
          if (w_stage_end) begin
            r_m1_start <= 1'b0;
            r_m2_start <= 1'b0;
            r_m3_start <= 1'b0;
            r_owner    <= OWN_NONE;
            r_state    <= S_GAP;
          end else if (WD_ON && (r_wd == WD_LAST)) begin
            r_m1_start <= 1'b0;
            r_m2_start <= 1'b0;
            r_m3_start <= 1'b0;
            r_err      <= 1'b1;
            r_owner    <= OWN_VGA;
            r_vga_en   <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_wd <= r_wd + 32'd1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_owner  <= OWN_VGA;
          r_vga_en <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// tb/tb_sram_stage_sequencer.sv - scoreboard bench for sram_stage_sequencer
module tb_sram_stage_sequencer;
  import sram_seq_pkg::*;

  localparam int TO = 100;
  localparam int WD = 50;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        uart_rx_i = 1'b1;
  logic [2:0]  stage_enable = 3'b000;
  logic        uart_rx_initialize, uart_rx_enable;
  logic        m1_start, m2_start, m3_start;
  logic        m1_end = 1'b0, m2_end = 1'b0, m3_end = 1'b0;
  logic [17:0] vga_address = '0;
  logic        vga_enable, busy, error;
  owner_t      owner;

  sram_stage_sequencer_if #(.ADDR_W(18), .DATA_W(16)) uart_if ();
  sram_stage_sequencer_if #(.ADDR_W(18), .DATA_W(16)) m1_if ();
  sram_stage_sequencer_if #(.ADDR_W(18), .DATA_W(16)) m2_if ();
  sram_stage_sequencer_if #(.ADDR_W(18), .DATA_W(16)) m3_if ();
  sram_stage_sequencer_if #(.ADDR_W(18), .DATA_W(16)) sram_if ();

  sram_stage_sequencer #(.UART_TIMEOUT(TO), .WATCHDOG_CYCLES(WD), .ADDR_W(18), .DATA_W(16)) dut (
    .CLOCK_50_I(clk), .resetn(resetn), .uart_rx_i(uart_rx_i), .stage_enable(stage_enable),
    .uart_rx_initialize(uart_rx_initialize), .uart_rx_enable(uart_rx_enable), .uart_req(uart_if),
    .m1_start(m1_start), .m2_start(m2_start), .m3_start(m3_start),
    .m1_end(m1_end), .m2_end(m2_end), .m3_end(m3_end),
    .m1_req(m1_if), .m2_req(m2_if), .m3_req(m3_if),
    .vga_address(vga_address), .vga_enable(vga_enable), .sram_req(sram_if),
    .owner(owner), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0] own;
    logic [2:0] st;   // {m1,m2,m3}
    logic vga, err, init, uen, bsy;
  } obs_t;
  typedef struct { int cyc; obs_t o; } ev_t;

  ev_t  exp_q[$];
  int   n_vec = 0, n_fail = 0, last_push = 0;
  bit   mon_on = 0;
  obs_t prev;
  logic [2:0] m_own = OWN_VGA;
  // model's view of the outputs
  logic [2:0] e_own = OWN_VGA;
  logic [2:0] e_st = 3'b000;
  logic e_vga = 1, e_err = 0, e_init = 0, e_uen = 0, e_busy = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, got, req);
    end
  endtask

  function automatic void push(input int c);
    ev_t e;
    e.cyc = c;
    e.o = '{own: e_own, st: e_st, vga: e_vga, err: e_err, init: e_init, uen: e_uen, bsy: e_busy};
    exp_q.push_back(e);
    last_push = c;
  endfunction

  function automatic void model_reset();
    e_own = OWN_VGA; e_st = 3'b000; e_vga = 1; e_err = 0; e_init = 0; e_uen = 0; e_busy = 0;
  endfunction

  // Monitor: every output change must match the next expected event; the SRAM port is checked every cycle
  always @(negedge clk) begin
    if (mon_on) begin
      obs_t obs;
      logic [17:0] ea;
      logic [15:0] ed;
      logic        ew;
      obs = '{own: owner, st: {m1_start, m2_start, m3_start}, vga: vga_enable, err: error,
              init: uart_rx_initialize, uen: uart_rx_enable, bsy: busy};
      if (obs != prev) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got cyc=%0d obs=%h, required no change", cyc, obs);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          m_own = e.o.own;
          if (e.cyc != cyc || e.o != obs) begin
            n_fail++;
            $display("FAIL event: got cyc=%0d obs=%h, required cyc=%0d obs=%h", cyc, obs, e.cyc, e.o);
          end
        end
        prev = obs;
      end
      ea = '0; ed = uart_if.write_data; ew = 1'b1;
      case (m_own)
        OWN_VGA:  ea = vga_address;
        OWN_UART: begin ea = uart_if.address; ew = uart_if.we_n; end
        OWN_M3:   begin ea = m3_if.address; ed = m3_if.write_data; ew = m3_if.we_n; end
        OWN_M2:   begin ea = m2_if.address; ed = m2_if.write_data; ew = m2_if.we_n; end
        OWN_M1:   begin ea = m1_if.address; ed = m1_if.write_data; ew = m1_if.we_n; end
        default:  ea = '0;
      endcase
      chk("sram_port", {sram_if.address, sram_if.write_data, sram_if.we_n}, {ea, ed, ew});
    end
  end

  // Requester noise so the mux check sees fresh values every cycle
  initial begin
    uart_if.we_n = 1'b1;
    forever begin
      @(posedge clk); #1;
      vga_address = 18'($urandom);
      uart_if.address = 18'($urandom); uart_if.write_data = 16'($urandom);
      m1_if.address = 18'($urandom); m1_if.write_data = 16'($urandom); m1_if.we_n = 1'($urandom);
      m2_if.address = 18'($urandom); m2_if.write_data = 16'($urandom); m2_if.we_n = 1'($urandom);
      m3_if.address = 18'($urandom); m3_if.write_data = 16'($urandom); m3_if.we_n = 1'($urandom);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic at_edge(input int e);
    while (cyc < e) tick();
  endtask

  task automatic set_end(input int s, input logic v);
    case (s)
      0: m3_end = v;
      1: m2_end = v;
      default: m1_end = v;
    endcase
  endtask

  // One full flow; dur > WD means the stage never ends; rst_m2 > 0 resets that many cycles into M2
  task automatic do_run(input logic [2:0] en, input int nwr, input int gap,
                        input int d3, input int d2, input int d1, input bit spur, input int rst_m2);
    int n, t, L, c;
    int dur[3];
    int st[3];
    bit stop;
    logic [2:0] own_of[3];
    own_of[0] = OWN_M3; own_of[1] = OWN_M2; own_of[2] = OWN_M1;
    dur[0] = d3; dur[1] = d2; dur[2] = d1;
    stage_enable = en;
    n = cyc;
    t = n + 1;
    e_own = OWN_UART; e_st = 0; e_vga = 0; e_err = 0; e_init = 1; e_uen = 0; e_busy = 1; push(t);
    e_init = 0; e_uen = 1; push(t + 1);
    e_uen = 0; push(t + 2);
    L = t + 3 + (nwr - 1) * gap;
    c = L + TO;
    e_own = OWN_NONE; push(c);
    stop = 0;
    for (int s = 0; s < 3; s++) begin
      st[s] = -1;
      if (!stop && en[s]) begin
        st[s] = c + 1;
        e_own = own_of[s]; e_st = 3'b001 << s; push(st[s]);
        if (s == 1 && rst_m2 > 0) begin
          model_reset(); push(st[s] + rst_m2); stop = 1;
        end else if (dur[s] <= WD) begin
          e_own = OWN_NONE; e_st = 0; c = st[s] + dur[s]; push(c);
        end else begin
          e_own = OWN_VGA; e_st = 0; e_vga = 1; e_err = 1; e_busy = 0; push(st[s] + WD); stop = 1;
        end
      end
    end
    if (!stop) begin
      e_own = OWN_VGA; e_vga = 1; e_busy = 0; push(c + 1);
    end

    uart_rx_i = 1'b0;
    at_edge(n + 1);
    uart_rx_i = 1'b1;
    for (int i = 0; i < nwr; i++) begin
      at_edge(t + 3 + i * gap - 1);
      uart_if.we_n = 1'b0;
      at_edge(t + 3 + i * gap);
      uart_if.we_n = 1'b1;
    end
    at_edge(L + TO);
    stage_enable = 3'($urandom);
    for (int s = 0; s < 3; s++) begin
      if (st[s] >= 0) begin
        if (s == 0 && spur && dur[s] >= 6 && dur[s] <= WD) begin
          at_edge(st[s] + 2);
          m1_end = 1; m2_end = 1; uart_rx_i = 0;
          at_edge(st[s] + 3);
          m1_end = 0; m2_end = 0; uart_rx_i = 1;
        end
        if (s == 1 && rst_m2 > 0) begin
          at_edge(st[s] + rst_m2);
          resetn = 1'b0;
          #1;
          chk("rst_m2_start", 32'(m2_start), 32'd0);
          chk("rst_owner", 32'(owner), 32'(OWN_VGA));
          chk("rst_we_n", 32'(sram_if.we_n), 32'd1);
          chk("rst_vga_en", 32'(vga_enable), 32'd1);
          at_edge(st[s] + rst_m2 + 3);
          resetn = 1'b1;
        end else if (dur[s] <= WD) begin
          at_edge(st[s] + dur[s] - 1);
          set_end(s, 1'b1);
          at_edge(st[s] + dur[s]);
          set_end(s, 1'b0);
        end
      end
    end
    at_edge(last_push + 6);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1 resetn = 1'b0;
    repeat (3) tick();
    chk("reset_owner", 32'(owner), 32'(OWN_VGA));
    chk("reset_vga_en", 32'(vga_enable), 32'd1);
    chk("reset_starts", 32'({m1_start, m2_start, m3_start}), 32'd0);
    chk("reset_init", 32'(uart_rx_initialize), 32'd0);
    chk("reset_uen", 32'(uart_rx_enable), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_we_n", 32'(sram_if.we_n), 32'd1);
    prev = '{own: OWN_VGA, st: 3'b000, vga: 1'b1, err: 1'b0, init: 1'b0, uen: 1'b0, bsy: 1'b0};
    resetn = 1'b1;
    mon_on = 1;
    repeat (3) tick();

    do_run(3'b111, 5, 10, 20, 30, int'($urandom_range(5, 45)), 1'b1, 0);
    do_run(3'b010, int'($urandom_range(1, 4)), int'($urandom_range(3, 20)), 0, int'($urandom_range(5, 45)), 0, 1'b0, 0);
    do_run(3'b001, 2, 7, 1000, 0, 0, 1'b0, 0);
    do_run(3'b111, 3, 5, WD, 20, 20, 1'b1, 10);
    repeat (5) tick();
    for (int r = 0; r < 6; r++)
      do_run(3'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(2, 30)),
             int'($urandom_range(5, 60)), int'($urandom_range(5, 60)), int'($urandom_range(5, 60)),
             1'($urandom), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
